// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and frame defaults for the TX and RX paths
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
endpackage

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte-serialising UART transmitter paced by an external baud tick
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 baud_ena,
  input  logic                 baud_tick,
  output logic                 tx
);
  localparam int SW = DATA_BITS + STOP_BITS + 1;
  localparam int CW = $clog2(DATA_BITS + STOP_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(DATA_BITS + STOP_BITS);
  uart_tx_state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tx_q, tx_d, done_q, done_d, ena_q, ena_d;
  logic accept, step, last;
  // The shift register back-fills with ones, so the line is already high when the final stop tick lands
  always_comb begin
    accept  = tx_valid && state_q == IDLE;
    step    = baud_tick && state_q != IDLE;
    last    = step && state_q == STOP && cnt_q == LAST_STOP;
    state_d = accept ? START
            : !step ? state_q
            : state_q == START ? DATA
            : (state_q == DATA && cnt_q == LAST_DATA) ? STOP
            : last ? IDLE
            : state_q;
    sr_d    = accept ? {{STOP_BITS{1'b1}}, tx_data, 1'b0} : step ? {1'b1, sr_q[SW-1:1]} : sr_q;
    cnt_d   = !step ? cnt_q : (state_q == START || last) ? '0 : cnt_q + 1'b1;
    tx_d    = step ? sr_q[0] : tx_q;
    ena_d   = accept ? 1'b1 : last ? 1'b0 : ena_q;
    done_d  = last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
    end
  end
  assign tx_ready = state_q == IDLE;
  assign tx_done  = done_q;
  assign baud_ena = ena_q;
  assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed scoreboard bench for uart_tx_frame with a BAUDRATE=4 tick model
module tb_uart_tx_frame;
  logic clk, rst, v8, v7, idle_t, sel;
  logic [7:0] data;
  logic ready8, done8, ena8, tx8, tick8, t8g;
  logic ready7, done7, ena7, tx7, tick7, t7g;
  logic [1:0] c8, c7;
  logic exp_q[$];
  int checks = 0;
  int fails = 0;

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1)) d8 (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(v8), .tx_ready(ready8),
    .tx_done(done8), .baud_ena(ena8), .baud_tick(tick8), .tx(tx8));
  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) d7 (
    .clk(clk), .rst(rst), .tx_data(data[6:0]), .tx_valid(v7), .tx_ready(ready7),
    .tx_done(done7), .baud_ena(ena7), .baud_tick(tick7), .tx(tx7));

  // Tick generator model: first tick one cycle after enable rises, then every 4 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c8 <= '0; t8g <= 1'b0; c7 <= '0; t7g <= 1'b0;
    end else begin
      c8  <= ena8 ? c8 + 2'd1 : 2'd0;
      t8g <= ena8 && c8 == 2'd0;
      c7  <= ena7 ? c7 + 2'd1 : 2'd0;
      t7g <= ena7 && c7 == 2'd0;
    end
  end
  assign tick8 = t8g | idle_t;
  assign tick7 = t7g;

  wire tx_m    = sel ? tx7 : tx8;
  wire ready_m = sel ? ready7 : ready8;
  wire done_m  = sel ? done7 : done8;
  wire ena_m   = sel ? ena7 : ena8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int nd, input int ns);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) exp_q.push_back(d[i]);
    for (int i = 0; i < ns; i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 100 && ready_m !== 1'b1; n++) step();
    chk("wait_ready", ready_m, 1'b1);
  endtask

  // Called at the first sample point after the accept edge; ends at the tx_done point
  task automatic frame_check(input int nb);
    logic b;
    chk("ena_up", ena_m, 1'b1);
    chk("ready_low", ready_m, 1'b0);
    chk("tx_hold_hi", tx_m, 1'b1);
    step();
    chk("pre_start_hi", tx_m, 1'b1);
    for (int i = 0; i < nb; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL sb_underflow observed=empty expected=bit%0d", i);
        b = 1'b1;
      end else b = exp_q.pop_front();
      repeat (4) begin
        step();
        chk($sformatf("bit%0d", i), tx_m, b);
        chk("done_low", done_m, 1'b0);
        chk("busy", ready_m, 1'b0);
      end
    end
    step();
    chk("done_pulse", done_m, 1'b1);
    chk("ready_back", ready_m, 1'b1);
    chk("ena_down", ena_m, 1'b0);
    chk("tx_end_hi", tx_m, 1'b1);
  endtask

  initial begin
    rst = 1'b0; v8 = 1'b0; v7 = 1'b0; idle_t = 1'b0; sel = 1'b0; data = 8'h00;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx8, 1'b1);
    chk("rst_ready", ready8, 1'b1);
    chk("rst_ena", ena8, 1'b0);
    chk("rst_done", done8, 1'b0);
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      idle_t = 1'b1;
      step();
      idle_t = 1'b0;
      step();
      chk("idle_tx", tx8, 1'b1);
      chk("idle_ready", ready8, 1'b1);
      chk("idle_ena", ena8, 1'b0);
      chk("idle_done", done8, 1'b0);
    end
    // 0x55 single frame
    wait_ready();
    data = 8'h55; v8 = 1'b1; push_frame(8'h55, 8, 1);
    step();
    v8 = 1'b0;
    frame_check(10);
    step();
    chk("done_one_cycle", done8, 1'b0);
    // 0xA3 with busy-time valid and data changes; 0xC3 is what is present when ready returns
    wait_ready();
    data = 8'hA3; v8 = 1'b1; push_frame(8'hA3, 8, 1);
    step();
    data = 8'h3C;
    fork
      frame_check(10);
      begin
        repeat (20) @(posedge clk);
        #2 data = 8'hC3;
        push_frame(8'hC3, 8, 1);
      end
    join
    step();
    v8 = 1'b0;
    frame_check(10);
    // back-to-back with valid held
    step();
    wait_ready();
    data = 8'h00; v8 = 1'b1; push_frame(8'h00, 8, 1);
    step();
    data = 8'hFF; push_frame(8'hFF, 8, 1);
    frame_check(10);
    step();
    v8 = 1'b0;
    frame_check(10);
    // reset during data bit 3 of 0x81
    step();
    wait_ready();
    data = 8'h81; v8 = 1'b1; push_frame(8'h81, 8, 1);
    step();
    v8 = 1'b0;
    repeat (19) step();
    chk("mid_bit3", tx8, 1'b0);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_tx", tx8, 1'b1);
    chk("mid_rst_ready", ready8, 1'b1);
    chk("mid_rst_ena", ena8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    step();
    rst = 1'b0;
    repeat (12) begin
      step();
      chk("post_rst_done", done8, 1'b0);
      chk("post_rst_tx", tx8, 1'b1);
    end
    wait_ready();
    data = 8'h81; v8 = 1'b1; push_frame(8'h81, 8, 1);
    step();
    v8 = 1'b0;
    frame_check(10);
    // 7 data bits, 2 stop bits
    step();
    sel = 1'b1;
    wait_ready();
    data = 8'h7F; v7 = 1'b1; push_frame(8'h7F, 7, 2);
    step();
    v7 = 1'b0;
    frame_check(10);
    step();
    chk("d7_done_one_cycle", done7, 1'b0);
    chk("sb_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
